seq_alu_unit: RTL and testbench

- Multi-cycle execution unit that consumes the 3-bit ALU select code produced by the R-type ALU control decoder, plus the two register operands and shamt.
- Logic/arithmetic ops complete in 1 cycle.
- Shifts run bit-serially, one position per cycle, to save area.
- Start/done handshake toward the datapath controller; sits between the register file read ports and the write-back mux.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_comb_core.sv | 45 ++++
 rtl/seq_alu_unit.sv | 106 ++++++++++
 tb/tb_seq_alu_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: select codes, FSM states and
// default widths.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_SHW   = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_NOR = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] sel);
    return (sel == ALU_SRL) || (sel == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle part of the ALU: logic ops, ADD/SUB with signed overflow, SLT.
// Shift codes produce zero here; the sequential wrapper handles them.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] value,
  output logic             ovf
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic             lt;

  assign sub     = (sel == ALU_SUB);
  assign b_eff   = sub ? ~b : b;
  assign sum     = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
  assign sum_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  // Compare directly instead of using sum's sign, so SLT is right even when a-b overflows.
  assign lt      = $signed(a) < $signed(b);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    value = '0;
    ovf   = 1'b0;
    case (sel)
      ALU_AND:          value = a & b;
      ALU_OR:           value = a | b;
      ALU_ADD, ALU_SUB: begin
        value = sum;
        ovf   = sum_ovf;
      end
      ALU_SLT:          value = {{(WIDTH-1){1'b0}}, lt};
      ALU_NOR:          value = ~(a | b);
      default:          ;
    endcase
  end

endmodule

// File: rtl/seq_alu_unit.sv
// Multi-cycle ALU: logic/arith ops finish in one cycle, shifts run bit-serially
// one position per cycle, with a start/busy/done handshake.
module seq_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = ALU_SHW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       select_bits_ALU,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  state_t           state, state_next;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   count;
  logic             shift_left;

  logic [WIDTH-1:0] core_value;
  logic             core_ovf;
  logic             start_shift;
  logic             last_step;
  logic [WIDTH-1:0] shift_value;
  logic [WIDTH-1:0] idle_value;
  logic             idle_ovf;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .a     (operand_a),
    .b     (operand_b),
    .sel   (select_bits_ALU),
    .value (core_value),
    .ovf   (core_ovf)
  );

  // A zero-distance shift is just a copy of b and completes like a 1-cycle op.
  assign start_shift = start && is_shift_op(select_bits_ALU) && (shamt != '0);
  assign idle_value  = is_shift_op(select_bits_ALU) ? operand_b : core_value;
  assign idle_ovf    = is_shift_op(select_bits_ALU) ? 1'b0 : core_ovf;
  assign shift_value = shift_left ? (work << 1) : (work >> 1);
  assign last_step   = (count == SHW'(1));
  assign busy        = (state == SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_shift) state_next = SHIFT;
      SHIFT:   if (last_step)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work       <= '0;
      count      <= '0;
      shift_left <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_shift) begin
            work       <= operand_b;
            count      <= shamt;
            shift_left <= (select_bits_ALU == ALU_SLL);
          end else if (start) begin
            result   <= idle_value;
            zero     <= (idle_value == '0);
            overflow <= idle_ovf;
            done     <= 1'b1;
          end
        end
        SHIFT: begin
          work  <= shift_value;
          count <= count - SHW'(1);
          if (last_step) begin
            result   <= shift_value;
            zero     <= (shift_value == '0);
            overflow <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Self-checking bench for seq_alu_unit: directed vector table, hand-written
// handshake/reset sequences, and randomized ops against a reference model.
module tb_seq_alu_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  select_bits_ALU;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  seq_alu_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .select_bits_ALU (select_bits_ALU),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .shamt           (shamt),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .zero            (zero),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model from the operation definitions, using wide signed arithmetic.
  function automatic exp_t model(input logic [2:0] sel, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
    exp_t   e;
    longint sa, sb, s;
    sa    = $signed(a);
    sb    = $signed(b);
    e.ovf = 1'b0;
    e.lat = 1;
    case (sel)
      ALU_AND: e.res = a & b;
      ALU_OR:  e.res = a | b;
      ALU_ADD: begin
        s = sa + sb;
        e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SLT: e.res = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SUB: begin
        s = sa - sb;
        e.res = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SRL: begin
        e.res = b >> sh;
        e.lat = (sh == 0) ? 1 : int'(sh) + 1;
      end
      ALU_SLL: begin
        e.res = b << sh;
        e.lat = (sh == 0) ? 1 : int'(sh) + 1;
      end
      default: e.res = ~(a | b);
    endcase
    return e;
  endfunction

  // Called #1 after a rising edge; launches one op and follows it to completion.
  // With scramble set, inputs and start are randomized every in-flight cycle.
  task automatic do_op(input string name, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp_res,
                       input logic exp_ovf, input int exp_lat, input bit scramble);
    int lat;
    int busy_cnt;
    select_bits_ALU = sel;
    operand_a       = a;
    operand_b       = b;
    shamt           = sh;
    start           = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat <= 40) begin
      if (busy) busy_cnt++;
      if (scramble) begin
        select_bits_ALU = 3'($urandom_range(0, 7));
        operand_a       = $urandom;
        operand_b       = $urandom;
        shamt           = 5'($urandom_range(0, 31));
        start           = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, 64'(result), 64'(exp_res));
    check({name, " zero"}, 64'(zero), 64'(exp_res == 32'd0));
    check({name, " overflow"}, 64'(overflow), 64'(exp_ovf));
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    @(posedge clk); #1;
    check({name, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    exp_t e;
    int   n;
    int   done_seen;
    logic [2:0]  r_sel;
    logic [31:0] r_a, r_b;
    logic [4:0]  r_sh;

    vecs[0]  = '{ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b1, 1};
    vecs[1]  = '{ALU_SUB, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b0, 1};
    vecs[2]  = '{ALU_SLT, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1};
    vecs[3]  = '{ALU_SLT, 32'h0000_0001, 32'h8000_0000, 5'd0,  32'h0000_0000, 1'b0, 1};
    vecs[4]  = '{ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0, 1'b0, 1};
    vecs[5]  = '{ALU_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'hFFF0_FFF0, 1'b0, 1};
    vecs[6]  = '{ALU_NOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h000F_000F, 1'b0, 1};
    vecs[7]  = '{ALU_SLL, 32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 32};
    vecs[8]  = '{ALU_SRL, 32'h0000_0000, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 5};
    vecs[9]  = '{ALU_SLL, 32'h0000_0000, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1};
    vecs[10] = '{ALU_SRL, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1};
    vecs[11] = '{ALU_SUB, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b1, 1};
    vecs[12] = '{ALU_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b0, 1};
    vecs[13] = '{ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0000, 5'd0,  32'h0000_0001, 1'b0, 1};

    reset = 1'b1;
    start = 1'b0;
    select_bits_ALU = ALU_AND;
    operand_a = '0;
    operand_b = '0;
    shamt     = '0;
    @(posedge clk); #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset zero", 64'(zero), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      do_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sh,
            vecs[i].res, vecs[i].ovf, vecs[i].lat, 1'b0);

    // Reset in the middle of a long shift: outputs clear at once, no late done.
    do_op("pre_reset", ALU_OR, 32'h0000_0F00, 32'h0000_00F0, 5'd0, 32'h0000_0FF0, 1'b0, 1, 1'b0);
    select_bits_ALU = ALU_SLL;
    operand_b = 32'h0000_0001;
    shamt = 5'd20;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid_shift busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("async_reset busy", 64'(busy), 64'd0);
    check("async_reset done", 64'(done), 64'd0);
    check("async_reset result", 64'(result), 64'd0);
    check("async_reset overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    done_seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("no_done_after_reset", 64'(done_seen), 64'd0);
    do_op("add_after_reset", ALU_ADD, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1, 1'b0);

    // Reset landing in the done cycle.
    select_bits_ALU = ALU_ADD;
    operand_a = 32'd1;
    operand_b = 32'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_cycle done", 64'(done), 64'd1);
    check("done_cycle result", 64'(result), 64'd2);
    #1 reset = 1'b1;
    #1;
    check("reset_in_done done", 64'(done), 64'd0);
    check("reset_in_done result", 64'(result), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back single-cycle ops: start in the done cycle is accepted.
    select_bits_ALU = ALU_ADD;
    operand_a = 32'd10;
    operand_b = 32'd20;
    start = 1'b1;
    @(posedge clk); #1;
    check("b2b first done", 64'(done), 64'd1);
    check("b2b first result", 64'(result), 64'd30);
    select_bits_ALU = ALU_SUB;
    operand_a = 32'd50;
    operand_b = 32'd8;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b second done", 64'(done), 64'd1);
    check("b2b second result", 64'(result), 64'd42);
    @(posedge clk); #1;
    check("b2b idle done", 64'(done), 64'd0);

    // Start pulses and input churn during SRL by 8 must not disturb it.
    do_op("srl8_churn", ALU_SRL, 32'h0, 32'hFF00_0000, 5'd8, 32'h00FF_0000, 1'b0, 9, 1'b1);

    // Start in the done cycle of a shift.
    select_bits_ALU = ALU_SRL;
    operand_b = 32'h0000_0100;
    shamt = 5'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n <= 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("shift_then_start latency", 64'(n), 64'd3);
    check("shift_then_start result", 64'(result), 64'h40);
    select_bits_ALU = ALU_ADD;
    operand_a = 32'd1;
    operand_b = 32'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("chained done", 64'(done), 64'd1);
    check("chained result", 64'(result), 64'd3);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      r_sel = 3'($urandom_range(0, 7));
      r_a   = $urandom;
      r_b   = $urandom;
      r_sh  = 5'($urandom_range(0, 31));
      if (i % 10 == 0) r_b = r_a;
      e = model(r_sel, r_a, r_b, r_sh);
      do_op($sformatf("rand%0d", i), r_sel, r_a, r_b, r_sh, e.res, e.ovf, e.lat, i[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
